// File: rtl/sr_pulse_gen.sv
// rtl/sr_pulse_gen.sv - set/clear request conditioner for the SR latch storage cells
// Synchronise, debounce and edge-detect two raw request lines, then issue exclusive strobes.
module sr_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_LEN       = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_set,
  input  logic raw_clr,
  output logic set_pulse,
  output logic clr_pulse,
  output logic q_mirror,
  output logic conflict,
  output logic busy
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PCNT_MAX = PW'(PULSE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SET,
    ST_CLR
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync_set;
  logic [SYNC_STAGES-1:0] r_sync_clr;
  logic [1:0]             w_sync;
  logic [1:0]             r_db;
  logic [1:0]             r_db_prev;
  logic [CW-1:0]          r_db_cnt [2];
  logic [1:0]             w_req;
  logic                   r_pend_set;
  logic                   r_pend_clr;
  logic                   w_idle;
  state_t                 r_state;
  logic [PW-1:0]          r_pcnt;
  logic                   r_set_pulse;
  logic                   r_clr_pulse;
  logic                   r_q_mirror;
  logic                   r_conflict;
  logic                   r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_set <= '0;
      r_sync_clr <= '0;
    end else begin
      r_sync_set <= {r_sync_set[SYNC_STAGES-2:0], raw_set};
      r_sync_clr <= {r_sync_clr[SYNC_STAGES-2:0], raw_clr};
    end
  end

  // Bit 0 carries the set channel, bit 1 the clear channel.
  assign w_sync = {r_sync_clr[SYNC_STAGES-1], r_sync_set[SYNC_STAGES-1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db      <= '0;
      r_db_prev <= '0;
      for (int i = 0; i < 2; i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      r_db_prev <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (w_sync[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == CNT_MAX) begin
          r_db[i]     <= w_sync[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_req  = r_db & ~r_db_prev;
  assign w_idle = (r_state == ST_IDLE);

  // Whatever is pending when idle gets consumed (strobe or conflict); a fresh request wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_set <= 1'b0;
      r_pend_clr <= 1'b0;
    end else begin
      r_pend_set <= w_req[0] | (r_pend_set & ~w_idle);
      r_pend_clr <= w_req[1] | (r_pend_clr & ~w_idle);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pcnt      <= '0;
      r_set_pulse <= 1'b0;
      r_clr_pulse <= 1'b0;
      r_q_mirror  <= 1'b0;
      r_conflict  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_conflict <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pend_set && r_pend_clr) begin
            r_conflict <= 1'b1;
          end else if (r_pend_set) begin
            r_state     <= ST_SET;
            r_pcnt      <= '0;
            r_set_pulse <= 1'b1;
            r_busy      <= 1'b1;
            r_q_mirror  <= 1'b1;
          end else if (r_pend_clr) begin
            r_state     <= ST_CLR;
            r_pcnt      <= '0;
            r_clr_pulse <= 1'b1;
            r_busy      <= 1'b1;
            r_q_mirror  <= 1'b0;
          end
        end
        ST_SET, ST_CLR: begin
          if (r_pcnt == PCNT_MAX) begin
            r_state     <= ST_IDLE;
            r_pcnt      <= '0;
            r_set_pulse <= 1'b0;
            r_clr_pulse <= 1'b0;
            r_busy      <= 1'b0;
          end else begin
            r_pcnt <= r_pcnt + PW'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_pcnt      <= '0;
          r_set_pulse <= 1'b0;
          r_clr_pulse <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign set_pulse = r_set_pulse;
  assign clr_pulse = r_clr_pulse;
  assign q_mirror  = r_q_mirror;
  assign conflict  = r_conflict;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sr_pulse_gen.sv
// tb/tb_sr_pulse_gen.sv - bench for sr_pulse_gen, PULSE_LEN=1 and PULSE_LEN=3 instances
// Shared raw inputs drive both instances; an edge-indexed model predicts every output.
module tb_sr_pulse_gen;

  localparam int S = 2;
  localparam int D = 4;

  logic       clk;
  logic       rst = 1'b1;
  logic       raw_set = 1'b0;
  logic       raw_clr = 1'b0;
  logic [1:0] set_o, clr_o, q_o, conf_o, busy_o;

  int n_cmp = 0;
  int n_bad = 0;

  sr_pulse_gen dut_a (
    .clk(clk), .rst(rst), .raw_set(raw_set), .raw_clr(raw_clr),
    .set_pulse(set_o[0]), .clr_pulse(clr_o[0]), .q_mirror(q_o[0]),
    .conflict(conf_o[0]), .busy(busy_o[0])
  );

  sr_pulse_gen #(.PULSE_LEN(3)) dut_b (
    .clk(clk), .rst(rst), .raw_set(raw_set), .raw_clr(raw_clr),
    .set_pulse(set_o[1]), .clr_pulse(clr_o[1]), .q_mirror(q_o[1]),
    .conflict(conf_o[1]), .busy(busy_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int plen(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: edges are numbered from reset release; raw history indexed by edge.
  int n;
  bit hs[$];
  bit hc[$];
  bit mdb[2], mreq[2], ps[2], pc[2], mq[2];
  int nxt[2], st[2], typ[2], conf_at[2];
  bit e_set[2], e_clr[2], e_busy[2], e_conf[2], e_q[2];

  function automatic bit syn(input int c, input int j);
    int k;
    k = j - S;
    if (k < 0) return 1'b0;
    return (c == 0) ? hs[k] : hc[k];
  endfunction

  always @(posedge clk or posedge rst) begin : model_blk
    bit rq[2];
    bit old, flip;
    if (rst) begin
      n = 0;
      hs.delete();
      hc.delete();
      for (int i = 0; i < 2; i++) begin
        mdb[i] = 0; mreq[i] = 0; ps[i] = 0; pc[i] = 0; mq[i] = 0;
        nxt[i] = 0; st[i] = -1000; typ[i] = 0; conf_at[i] = -1000;
        e_set[i] = 0; e_clr[i] = 0; e_busy[i] = 0; e_conf[i] = 0; e_q[i] = 0;
      end
    end else begin
      n++;
      hs.push_back(raw_set);
      hc.push_back(raw_clr);
      rq = mreq;
      // A level is accepted once the synced value disagreed for the last D edges.
      for (int c = 0; c < 2; c++) begin
        old  = mdb[c];
        flip = 1;
        for (int j = n - D; j <= n - 1; j++) begin
          if (syn(c, j) == old) flip = 0;
        end
        if (flip) mdb[c] = ~old;
        mreq[c] = mdb[c] & ~old;
      end
      for (int i = 0; i < 2; i++) begin
        if (n >= nxt[i]) begin
          if (ps[i] && pc[i]) begin
            conf_at[i] = n; ps[i] = 0; pc[i] = 0;
          end else if (ps[i]) begin
            st[i] = n; typ[i] = 0; nxt[i] = n + plen(i) + 1; mq[i] = 1; ps[i] = 0;
          end else if (pc[i]) begin
            st[i] = n; typ[i] = 1; nxt[i] = n + plen(i) + 1; mq[i] = 0; pc[i] = 0;
          end
        end
        ps[i] = ps[i] | rq[0];
        pc[i] = pc[i] | rq[1];
        e_busy[i] = (n >= st[i]) && (n < st[i] + plen(i));
        e_set[i]  = e_busy[i] && (typ[i] == 0);
        e_clr[i]  = e_busy[i] && (typ[i] == 1);
        e_conf[i] = (conf_at[i] == n);
        e_q[i]    = mq[i];
      end
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m_set%0d", i), set_o[i], e_set[i]);
      chk($sformatf("m_clr%0d", i), clr_o[i], e_clr[i]);
      chk($sformatf("m_busy%0d", i), busy_o[i], e_busy[i]);
      chk($sformatf("m_conf%0d", i), conf_o[i], e_conf[i]);
      chk($sformatf("m_q%0d", i), q_o[i], e_q[i]);
    end
  end

  // Per-test activity counters for the literal expectations.
  int cs[2], cc[2], ccf[2], rs[2], ov[2];
  bit prev_set[2];
  int g_cyc, last_set_b, first_clr_b;

  task automatic clr_cnt();
    for (int i = 0; i < 2; i++) begin
      cs[i] = 0; cc[i] = 0; ccf[i] = 0; rs[i] = 0; ov[i] = 0;
      prev_set[i] = set_o[i];
    end
    g_cyc = 0; last_set_b = -1; first_clr_b = -1;
  endtask

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
      g_cyc++;
      for (int i = 0; i < 2; i++) begin
        cs[i]  += int'(set_o[i]);
        cc[i]  += int'(clr_o[i]);
        ccf[i] += int'(conf_o[i]);
        if (set_o[i] && clr_o[i]) ov[i]++;
        if (set_o[i] && !prev_set[i]) rs[i]++;
        prev_set[i] = set_o[i];
      end
      if (set_o[1]) last_set_b = g_cyc;
      if (clr_o[1] && first_clr_b < 0) first_clr_b = g_cyc;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_set_a", set_o[0], 1'b0);
    chk("rst_q_b", q_o[1], 1'b0);
    chk("rst_busy_b", busy_o[1], 1'b0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_set_a", set_o[0], 1'b0);
    chk("post_rst_q_a", q_o[0], 1'b0);
    cyc(5);

    // 1: latency of a held set request
    raw_set = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("t1_set_a", set_o[0], k == 7);
      chk("t1_q_a", q_o[0], k >= 7);
      chk("t1_busy_a", busy_o[0], k == 7);
      chk("t1_set_b", set_o[1], (k >= 7) && (k <= 9));
    end
    cyc(15);
    raw_set = 1'b0;
    cyc(15);

    // 2: short clear glitch is filtered
    clr_cnt();
    raw_clr = 1'b1;
    cyc(3);
    raw_clr = 1'b0;
    cyc(15);
    chk_int("t2_clr_a", cc[0], 0);
    chk_int("t2_clr_b", cc[1], 0);
    chk("t2_q_a", q_o[0], 1'b1);
    chk("t2_q_b", q_o[1], 1'b1);

    // 3: simultaneous requests collide
    clr_cnt();
    raw_set = 1'b1;
    raw_clr = 1'b1;
    cyc(15);
    raw_set = 1'b0;
    raw_clr = 1'b0;
    cyc(15);
    chk_int("t3_conf_a", ccf[0], 1);
    chk_int("t3_conf_b", ccf[1], 1);
    chk_int("t3_set_a", cs[0], 0);
    chk_int("t3_clr_a", cc[0], 0);
    chk("t3_q_a", q_o[0], 1'b1);

    // 4: set then clear one cycle later
    clr_cnt();
    raw_set = 1'b1;
    cyc(1);
    raw_clr = 1'b1;
    cyc(20);
    raw_set = 1'b0;
    raw_clr = 1'b0;
    cyc(15);
    chk_int("t4_set_b", cs[1], 3);
    chk_int("t4_clr_b", cc[1], 3);
    chk_int("t4_ovl_b", ov[1], 0);
    chk_int("t4_gap_b", first_clr_b - last_set_b, 2);
    chk("t4_q_b", q_o[1], 1'b0);
    chk_int("t4_set_a", cs[0], 1);
    chk_int("t4_clr_a", cc[0], 1);
    chk("t4_q_a", q_o[0], 1'b0);

    // 5: reset during the second cycle of a long set strobe
    raw_set = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    chk("t5_pre_set_b", set_o[1], 1'b1);
    chk("t5_pre_q_b", q_o[1], 1'b1);
    #2;
    rst = 1'b1;
    raw_set = 1'b0;
    #1;
    chk("t5_set_b", set_o[1], 1'b0);
    chk("t5_q_b", q_o[1], 1'b0);
    chk("t5_busy_b", busy_o[1], 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clr_cnt();
    cyc(25);
    chk_int("t5_after_set_a", cs[0], 0);
    chk_int("t5_after_set_b", cs[1], 0);
    chk_int("t5_after_clr_b", cc[1], 0);

    // 6: toggling set only strobes on rising edges
    clr_cnt();
    raw_set = 1'b0; cyc(10);
    raw_set = 1'b1; cyc(10);
    raw_set = 1'b0; cyc(10);
    raw_set = 1'b1; cyc(10);
    raw_set = 1'b0; cyc(20);
    chk_int("t6_rise_a", rs[0], 2);
    chk_int("t6_rise_b", rs[1], 2);
    chk_int("t6_set_b", cs[1], 6);
    chk_int("t6_clr_a", cc[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
